bus_host_ctrl: RTL and testbench

- Single-outstanding bus initiator. Drives the same req/gnt/rvalid device bus used by the system peripherals (GPIO, timer, UART).
- Takes word read/write commands on a valid/ready command port, performs one bus transaction per command, and returns rdata/error on a valid/ready response port.
- Used by the debug/test sequencer and for self-test of peripherals. Includes a response timeout so a dead responder cannot hang the host.

---
 rtl/bus_host_ctrl.sv | 160 ++++++++++++++++
 tb/tb_bus_host_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_host_ctrl.sv
// Single-outstanding req/gnt/rvalid bus initiator with a valid/ready command port,
// a valid/ready response port and a grant-to-rvalid response timeout.
module bus_host_ctrl #(
    parameter int unsigned TimeoutCycles = 64,
    parameter int unsigned AddrWidth     = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cmd_valid_i,
    output logic                 cmd_ready_o,
    input  logic                 cmd_we_i,
    input  logic [AddrWidth-1:0] cmd_addr_i,
    input  logic [3:0]           cmd_be_i,
    input  logic [31:0]          cmd_wdata_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [31:0]          rsp_rdata_o,
    output logic                 rsp_err_o,
    output logic                 rsp_timeout_o,
    output logic                 host_req_o,
    input  logic                 host_gnt_i,
    output logic [AddrWidth-1:0] host_addr_o,
    output logic                 host_we_o,
    output logic [3:0]           host_be_o,
    output logic [31:0]          host_wdata_o,
    input  logic                 host_rvalid_i,
    input  logic [31:0]          host_rdata_i,
    input  logic                 host_err_i
);

    localparam int unsigned CntW      = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
    localparam logic [CntW-1:0] CntLimit = CntW'(TimeoutCycles);
    localparam bit          TimeoutEn = (TimeoutCycles != 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_RSP
    } state_t;

    state_t                 r_state, w_state_nxt;
    logic                   r_req, w_req_nxt;
    logic [AddrWidth-1:0]   r_addr, w_addr_nxt;
    logic                   r_we, w_we_nxt;
    logic [3:0]             r_be, w_be_nxt;
    logic [31:0]            r_wdata, w_wdata_nxt;
    logic                   r_rsp_valid, w_rsp_valid_nxt;
    logic [31:0]            r_rsp_rdata, w_rsp_rdata_nxt;
    logic                   r_rsp_err, w_rsp_err_nxt;
    logic                   r_rsp_tmo, w_rsp_tmo_nxt;
    logic [CntW-1:0]        r_cnt, w_cnt_nxt;
    logic                   w_timeout_hit;
    logic                   w_unused_addr_lsb;

    // Byte-lane bits of the command address never reach the word-aligned bus.
    assign w_unused_addr_lsb = ^cmd_addr_i[1:0];

    assign cmd_ready_o   = (r_state == S_IDLE) && !rst_i;
    assign w_timeout_hit = TimeoutEn && (r_cnt == CntLimit - CntW'(1));

    assign host_req_o    = r_req;
    assign host_addr_o   = r_addr;
    assign host_we_o     = r_we;
    assign host_be_o     = r_be;
    assign host_wdata_o  = r_wdata;
    assign rsp_valid_o   = r_rsp_valid;
    assign rsp_rdata_o   = r_rsp_rdata;
    assign rsp_err_o     = r_rsp_err;
    assign rsp_timeout_o = r_rsp_tmo;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= S_IDLE;
            r_req       <= 1'b0;
            r_addr      <= '0;
            r_we        <= 1'b0;
            r_be        <= '0;
            r_wdata     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_rsp_tmo   <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_req       <= w_req_nxt;
            r_addr      <= w_addr_nxt;
            r_we        <= w_we_nxt;
            r_be        <= w_be_nxt;
            r_wdata     <= w_wdata_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_rdata <= w_rsp_rdata_nxt;
            r_rsp_err   <= w_rsp_err_nxt;
            r_rsp_tmo   <= w_rsp_tmo_nxt;
            r_cnt       <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_req_nxt       = r_req;
        w_addr_nxt      = r_addr;
        w_we_nxt        = r_we;
        w_be_nxt        = r_be;
        w_wdata_nxt     = r_wdata;
        w_rsp_valid_nxt = r_rsp_valid;
        w_rsp_rdata_nxt = r_rsp_rdata;
        w_rsp_err_nxt   = r_rsp_err;
        w_rsp_tmo_nxt   = r_rsp_tmo;
        w_cnt_nxt       = r_cnt;

        case (r_state)
            S_IDLE: begin
                if (cmd_valid_i && cmd_ready_o) begin
                    w_addr_nxt  = {cmd_addr_i[AddrWidth-1:2], 2'b00};
                    w_we_nxt    = cmd_we_i;
                    w_be_nxt    = cmd_be_i;
                    w_wdata_nxt = cmd_wdata_i;
                    w_req_nxt   = 1'b1;
                    w_state_nxt = S_REQ;
                end
            end
            // Request is never withdrawn before grant, so no timeout here.
            S_REQ: begin
                if (host_gnt_i) begin
                    w_req_nxt   = 1'b0;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_WAIT;
                end
            end
            // rvalid has priority over a timeout expiring in the same cycle.
            S_WAIT: begin
                if (host_rvalid_i) begin
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_err_nxt   = host_err_i;
                    w_rsp_tmo_nxt   = 1'b0;
                    w_rsp_rdata_nxt = (r_we || host_err_i) ? 32'h0 : host_rdata_i;
                    w_state_nxt     = S_RSP;
                end else if (w_timeout_hit) begin
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_err_nxt   = 1'b1;
                    w_rsp_tmo_nxt   = 1'b1;
                    w_rsp_rdata_nxt = 32'h0;
                    w_state_nxt     = S_RSP;
                end else if (r_cnt != CntLimit) begin
                    w_cnt_nxt = r_cnt + CntW'(1);
                end
            end
            S_RSP: begin
                if (rsp_ready_i) begin
                    w_rsp_valid_nxt = 1'b0;
                    w_state_nxt     = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_bus_host_ctrl.sv
// Bench for bus_host_ctrl: GPIO-style responder model, response scoreboard and
// directed latency/stability checks.
module tb_bus_host_ctrl;

    localparam int unsigned Tmo = 8;
    localparam int unsigned AW  = 32;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          cmd_valid_i, cmd_ready_o, cmd_we_i;
    logic [AW-1:0] cmd_addr_i;
    logic [3:0]    cmd_be_i;
    logic [31:0]   cmd_wdata_i;
    logic          rsp_valid_o, rsp_ready_i, rsp_err_o, rsp_timeout_o;
    logic [31:0]   rsp_rdata_o;
    logic          host_req_o, host_gnt_i, host_we_o;
    logic [AW-1:0] host_addr_o;
    logic [3:0]    host_be_o;
    logic [31:0]   host_wdata_o;
    logic          host_rvalid_i, host_err_i;
    logic [31:0]   host_rdata_i;

    // responder model controls
    logic          gnt_en, auto_en, err_mode, inj_rvalid, inj_err;
    logic [31:0]   inj_rdata;
    logic          pend = 1'b0;
    logic [31:0]   pend_rdata = 32'h0;
    logic [31:0]   mem [16] = '{default: 32'h0};

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic        tmo;
    } rsp_t;

    rsp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    bus_host_ctrl #(.TimeoutCycles(Tmo), .AddrWidth(AW)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
        .cmd_addr_i(cmd_addr_i), .cmd_be_i(cmd_be_i), .cmd_wdata_i(cmd_wdata_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
        .rsp_err_o(rsp_err_o), .rsp_timeout_o(rsp_timeout_o),
        .host_req_o(host_req_o), .host_gnt_i(host_gnt_i), .host_addr_o(host_addr_o),
        .host_we_o(host_we_o), .host_be_o(host_be_o), .host_wdata_o(host_wdata_o),
        .host_rvalid_i(host_rvalid_i), .host_rdata_i(host_rdata_i), .host_err_i(host_err_i)
    );

    // GPIO-style responder: combinational grant, rvalid one cycle later.
    assign host_gnt_i    = host_req_o & gnt_en;
    assign host_rvalid_i = pend | inj_rvalid;
    assign host_rdata_i  = inj_rvalid ? inj_rdata : pend_rdata;
    assign host_err_i    = inj_rvalid ? inj_err : (pend & err_mode);

    always @(posedge clk) begin
        pend <= host_req_o && host_gnt_i && auto_en && !rst_i;
        if (host_req_o && host_gnt_i && auto_en) begin
            pend_rdata <= mem[host_addr_o[5:2]];
            if (host_we_o)
                for (int b = 0; b < 4; b++)
                    if (host_be_o[b]) mem[host_addr_o[5:2]][8*b +: 8] <= host_wdata_o[8*b +: 8];
        end
    end

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic rsp_t mk(input logic [31:0] rdata, input logic err, input logic tmo);
        rsp_t r;
        r.rdata = rdata;
        r.err   = err;
        r.tmo   = tmo;
        return r;
    endfunction

    // Scoreboard monitor: every completed response handshake is compared.
    always @(negedge clk) begin
        if (!rst_i && rsp_valid_o && rsp_ready_i) begin
            if (exp_q.size() == 0) begin
                check("unexpected_rsp", 96'(rsp_valid_o), 96'(0));
            end else begin
                rsp_t e;
                e = exp_q.pop_front();
                check("rsp", 96'({rsp_rdata_o, rsp_err_o, rsp_timeout_o}), 96'(e));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic we, input logic [31:0] addr, input logic [3:0] be,
                            input logic [31:0] wd);
        int n;
        cmd_valid_i = 1'b1;
        cmd_we_i    = we;
        cmd_addr_i  = addr;
        cmd_be_i    = be;
        cmd_wdata_i = wd;
        n = 0;
        while (!cmd_ready_o && n < 100) begin
            tick();
            n++;
        end
        check("cmd_accept", 96'(cmd_ready_o), 96'(1));
        tick();
        cmd_valid_i = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || !cmd_ready_o) && n < 200) begin
            tick();
            n++;
        end
        check("drain", 96'({exp_q.size() == 0, cmd_ready_o}), 96'(2'b11));
    endtask

    task automatic check_all_zero(input string name);
        check(name, 96'({host_req_o, host_we_o, host_be_o, host_addr_o, host_wdata_o}), 96'(0));
        check({name, "_rsp"}, 96'({rsp_valid_o, rsp_err_o, rsp_timeout_o, rsp_rdata_o}), 96'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1'b1; cmd_valid_i = 1'b0; cmd_we_i = 1'b0; cmd_addr_i = '0;
        cmd_be_i = '0; cmd_wdata_i = '0; rsp_ready_i = 1'b1;
        gnt_en = 1'b1; auto_en = 1'b1; err_mode = 1'b0;
        inj_rvalid = 1'b0; inj_err = 1'b0; inj_rdata = '0;

        // Reset state
        tick(); tick();
        @(negedge clk);
        check("rst_cmd_ready", 96'(cmd_ready_o), 96'(0));
        check_all_zero("rst_outputs");
        tick();
        rst_i = 1'b0;

        // Write with minimum latency
        tick();
        exp_q.push_back(mk(32'h0, 1'b0, 1'b0));
        send_cmd(1'b1, 32'h0, 4'b0011, 32'h1234_A5A5);
        @(negedge clk);
        check("wr_c1_req", 96'({host_req_o, host_we_o, host_addr_o, host_be_o, host_wdata_o}),
              96'({1'b1, 1'b1, 32'h0, 4'b0011, 32'h1234_A5A5}));
        tick(); @(negedge clk);
        check("wr_c2", 96'({host_req_o, rsp_valid_o}), 96'(2'b00));
        tick(); @(negedge clk);
        check("wr_c3_rsp_valid", 96'(rsp_valid_o), 96'(1));
        tick(); @(negedge clk);
        check("wr_c4", 96'({cmd_ready_o, rsp_valid_o}), 96'(2'b10));

        // Read back; address low bits dropped
        tick();
        exp_q.push_back(mk(32'h0000_A5A5, 1'b0, 1'b0));
        send_cmd(1'b0, 32'h2, 4'hF, 32'h0);
        @(negedge clk);
        check("rd_addr_align", 96'({host_req_o, host_we_o, host_addr_o}), 96'({1'b1, 1'b0, 32'h0}));
        wait_idle();

        // Grant stall for 10 cycles
        gnt_en = 1'b0;
        exp_q.push_back(mk(32'h0, 1'b0, 1'b0));
        send_cmd(1'b1, 32'h4, 4'hF, 32'hCAFE_F00D);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("stall_hold",
                  96'({host_req_o, rsp_valid_o, cmd_ready_o, host_addr_o, host_be_o, host_wdata_o}),
                  96'({1'b1, 1'b0, 1'b0, 32'h4, 4'hF, 32'hCAFE_F00D}));
            tick();
        end
        gnt_en = 1'b1;
        @(negedge clk);
        check("stall_gnt_cycle", 96'({host_req_o, rsp_valid_o}), 96'(2'b10));
        tick(); @(negedge clk);
        check("stall_gnt_p1", 96'({host_req_o, rsp_valid_o}), 96'(2'b00));
        tick(); @(negedge clk);
        check("stall_gnt_p2", 96'(rsp_valid_o), 96'(1));
        wait_idle();

        exp_q.push_back(mk(32'hCAFE_F00D, 1'b0, 1'b0));
        send_cmd(1'b0, 32'h4, 4'hF, 32'h0);
        wait_idle();

        // Timeout after 8 WAIT cycles; late rvalid ignored
        auto_en = 1'b0;
        exp_q.push_back(mk(32'h0, 1'b1, 1'b1));
        send_cmd(1'b0, 32'h8, 4'hF, 32'h0);
        repeat (8) tick();
        @(negedge clk);
        check("tmo_c9_none", 96'(rsp_valid_o), 96'(0));
        tick(); @(negedge clk);
        check("tmo_c10_rsp", 96'({rsp_valid_o, rsp_err_o, rsp_timeout_o}), 96'(3'b111));
        tick(); tick(); tick();
        inj_rvalid = 1'b1; inj_rdata = 32'h5555_5555; inj_err = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("tmo_late_rvalid", 96'({rsp_valid_o, cmd_ready_o}), 96'(2'b01));
            tick();
            inj_rvalid = 1'b0;
        end
        wait_idle();
        auto_en = 1'b1;

        // Error response zeroes read data
        exp_q.push_back(mk(32'h0, 1'b0, 1'b0));
        send_cmd(1'b1, 32'hC, 4'hF, 32'hDEAD_BEEF);
        wait_idle();
        err_mode = 1'b1;
        exp_q.push_back(mk(32'h0, 1'b1, 1'b0));
        send_cmd(1'b0, 32'hC, 4'hF, 32'h0);
        wait_idle();
        err_mode = 1'b0;

        // rvalid in the limit cycle wins over the timeout
        auto_en = 1'b0;
        exp_q.push_back(mk(32'h1357_9BDF, 1'b0, 1'b0));
        send_cmd(1'b0, 32'h4, 4'hF, 32'h0);
        repeat (8) tick();
        inj_rvalid = 1'b1; inj_rdata = 32'h1357_9BDF; inj_err = 1'b0;
        tick();
        inj_rvalid = 1'b0;
        @(negedge clk);
        check("race_rsp", 96'({rsp_valid_o, rsp_timeout_o}), 96'(2'b10));
        wait_idle();
        auto_en = 1'b1;

        // Response backpressure with a second command waiting
        rsp_ready_i = 1'b0;
        exp_q.push_back(mk(32'h0000_A5A5, 1'b0, 1'b0));
        send_cmd(1'b0, 32'h0, 4'hF, 32'h0);
        cmd_valid_i = 1'b1; cmd_we_i = 1'b1; cmd_addr_i = 32'h10;
        cmd_be_i = 4'b1000; cmd_wdata_i = 32'hAB00_0000;
        exp_q.push_back(mk(32'h0, 1'b0, 1'b0));
        tick(); tick();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_hold", 96'({rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o, cmd_ready_o}),
                  96'({1'b1, 32'h0000_A5A5, 1'b0, 1'b0, 1'b0}));
            tick();
        end
        rsp_ready_i = 1'b1;
        tick(); @(negedge clk);
        check("bp_after_hs", 96'({cmd_ready_o, rsp_valid_o}), 96'(2'b10));
        tick();
        cmd_valid_i = 1'b0;
        @(negedge clk);
        check("bp_second_cmd", 96'({host_req_o, host_addr_o, host_be_o}), 96'({1'b1, 32'h10, 4'b1000}));
        wait_idle();

        exp_q.push_back(mk(32'hAB00_0000, 1'b0, 1'b0));
        send_cmd(1'b0, 32'h10, 4'hF, 32'h0);
        wait_idle();

        // Reset during WAIT
        auto_en = 1'b0;
        send_cmd(1'b0, 32'h8, 4'hF, 32'h0);
        tick();
        tick();
        rst_i = 1'b1;
        @(negedge clk);
        check("rstw_cmd_ready", 96'(cmd_ready_o), 96'(0));
        tick();
        rst_i = 1'b0;
        inj_rvalid = 1'b1; inj_rdata = 32'h7777_7777; inj_err = 1'b0;
        @(negedge clk);
        check_all_zero("rstw_outputs");
        tick();
        inj_rvalid = 1'b0;
        @(negedge clk);
        check("rstw_ignore_rvalid", 96'({rsp_valid_o, cmd_ready_o}), 96'(2'b01));
        tick(); @(negedge clk);
        check("rstw_quiet", 96'({rsp_valid_o, host_req_o}), 96'(2'b00));
        auto_en = 1'b1;
        tick();
        exp_q.push_back(mk(32'hCAFE_F00D, 1'b0, 1'b0));
        send_cmd(1'b0, 32'h4, 4'hF, 32'h0);
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
